// File: rtl/spike_dec_pkg.sv
// Shared types and default widths for the spike rate decoder.
package spike_dec_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;
  localparam int DEF_ISI_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !at_max)
      count <= count + W'(1);
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder with optional inter-spike-interval tracking.
// Optional ISI logic is built only when SPIKE_RATE_DECODER_ISI_EN is defined.
//
//   state | meaning
//   IDLE  | decoding disabled, counters held at zero
//   COUNT | counting spikes in consecutive windows of win_len cycles
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [ISI_W-1:0] out_isi,
  output logic             overrun,
  output logic             busy
);

  state_t state, state_nxt;

  logic             spike_q;
  logic             spike_ev;
  logic             active;
  logic             win_end;
  logic             load;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_last;
  logic [CNT_W-1:0] spk_cnt;
  logic             spk_max;
  logic [CNT_W-1:0] spk_total;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en)  state_nxt = COUNT;
      COUNT: if (!en) state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == COUNT);
  assign active   = (state == COUNT) && en;
  assign spike_ev = spike_in & ~spike_q;
  assign win_end  = active && (win_cnt == win_last);
  assign load     = win_end && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) spike_q <= 1'b0;
    else     spike_q <= spike_in;
  end

  // win_last holds max(win_len,1)-1, captured at every window start
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      win_last <= '0;
    end else begin
      if (!active || win_end) win_cnt <= '0;
      else                    win_cnt <= win_cnt + WIN_W'(1);
      if ((state == IDLE && en) || win_end)
        win_last <= (win_len == '0) ? '0 : win_len - WIN_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!active || win_end),
    .inc    (active && spike_ev),
    .count  (spk_cnt),
    .at_max (spk_max)
  );

  // A spike on the window-end cycle still belongs to the ending window.
  assign spk_total = (spike_ev && !spk_max) ? spk_cnt + CNT_W'(1) : spk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_count <= spk_total;
    end else if (win_end) begin
      overrun   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic [ISI_W-1:0] isi_cnt;
  logic             isi_max;
  logic [ISI_W-1:0] isi_inc;
  logic [ISI_W-1:0] isi_last;
  logic [ISI_W-1:0] isi_report;
  logic             have_prev;

  sat_counter #(.W(ISI_W)) u_isi_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!active || spike_ev),
    .inc    (active),
    .count  (isi_cnt),
    .at_max (isi_max)
  );

  assign isi_inc    = isi_max ? isi_cnt : isi_cnt + ISI_W'(1);
  assign isi_report = (spike_ev && have_prev) ? isi_inc : isi_last;

  // isi_last survives leaving COUNT; only have_prev is forgotten
  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
      isi_last  <= '0;
      out_isi   <= '0;
    end else begin
      if (!active)       have_prev <= 1'b0;
      else if (spike_ev) have_prev <= 1'b1;
      if (active && spike_ev && have_prev) isi_last <= isi_inc;
      if (load) out_isi <= isi_report;
    end
  end
`else
  assign out_isi = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder; ISI expectations follow SPIKE_RATE_DECODER_ISI_EN.
module tb_spike_rate_decoder;

  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;
  localparam int ISI_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int ISI_MAX = (1 << ISI_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             spike_in;
  logic [WIN_W-1:0] win_len;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ISI_W-1:0] out_isi;
  logic             overrun;
  logic             busy;

  int errors = 0;
  int checks = 0;

  bit stim[$];

  always #5 clk = ~clk;

  spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spike_in  (spike_in),
    .win_len   (win_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_isi   (out_isi),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Model: stim[k] is spike_in on COUNT cycle k; input was low before cycle 0.
  function automatic bit is_event(int k);
    return stim[k] && (k == 0 || !stim[k-1]);
  endfunction

  function automatic int exp_count(int first, int last);
    int n = 0;
    for (int k = first; k <= last; k++) if (is_event(k)) n++;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic int exp_isi(int last);
    int prev = -1;
    int cur  = -1;
    for (int k = 0; k <= last; k++) begin
      if (is_event(k)) begin
        prev = cur;
        cur  = k;
      end
    end
`ifdef SPIKE_RATE_DECODER_ISI_EN
    if (prev < 0) return 0;
    return (cur - prev > ISI_MAX) ? ISI_MAX : cur - prev;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1; win_len = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_count(input int len);
    win_len = WIN_W'(len); en = 1'b1; spike_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; spike_in = 1'b1; out_ready = 1'b0; win_len = 16'd3;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    checks++; if (out_isi !== '0) begin errors++; $display("FAIL reset_isi got=%0d exp=0", out_isi); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  // Runs stim through windows of win_len=len with out_ready held high.
  task automatic run_stream(input int len, input int nwin, input string tag);
    int le;
    le = (len == 0) ? 1 : len;
    do_reset();
    start_count(len);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got=%b exp=1", tag, busy); end
    for (int k = 0; k < le * nwin; k++) begin
      logic is_end;
      spike_in = stim[k];
      tick();
      is_end = ((k % le) == le - 1);
      checks++;
      if (out_valid !== is_end) begin
        errors++; $display("FAIL %s valid k=%0d got=%b exp=%b", tag, k, out_valid, is_end);
      end
      if (is_end) begin
        checks++;
        if (out_count !== CNT_W'(exp_count(k - le + 1, k))) begin
          errors++; $display("FAIL %s count k=%0d got=%0d exp=%0d", tag, k, out_count, exp_count(k - le + 1, k));
        end
        checks++;
        if (out_isi !== ISI_W'(exp_isi(k))) begin
          errors++; $display("FAIL %s isi k=%0d got=%0d exp=%0d", tag, k, out_isi, exp_isi(k));
        end
      end
    end
    en = 1'b0; spike_in = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    stim.delete();
    for (int k = 0; k < 10; k++) stim.push_back(k == 2 || k == 5 || k == 8);
    run_stream(10, 1, "directed");
  endtask

  task automatic test_held_high();
    stim.delete();
    for (int k = 0; k < 20; k++) stim.push_back(1'b1);
    run_stream(10, 2, "held_high");
  endtask

  task automatic test_saturate();
    stim.delete();
    for (int k = 0; k < 600; k++) stim.push_back(k % 2 == 0);
    run_stream(600, 1, "saturate");
  endtask

  task automatic test_random();
    int lens[5] = '{0, 1, 3, 7, 13};
    foreach (lens[i]) begin
      int le;
      le = (lens[i] == 0) ? 1 : lens[i];
      stim.delete();
      for (int k = 0; k < le * 4; k++) stim.push_back($urandom_range(0, 2) == 0);
      run_stream(lens[i], 4, "random");
    end
  endtask

  task automatic test_backpressure();
    int first_cnt;
    int first_isi;
    do_reset();
    stim.delete();
    for (int k = 0; k < 20; k++) stim.push_back(k == 1 || k == 3 || k == 12 || k == 15);
    first_cnt = exp_count(0, 9);
    first_isi = exp_isi(9);
    out_ready = 1'b0;
    start_count(10);
    for (int k = 0; k < 20; k++) begin
      spike_in = stim[k];
      tick();
      if (k == 9) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_early_overrun got=%b exp=0", overrun); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
    checks++; if (out_count !== CNT_W'(first_cnt)) begin errors++; $display("FAIL bp_held_count got=%0d exp=%0d", out_count, first_cnt); end
    checks++; if (out_isi !== ISI_W'(first_isi)) begin errors++; $display("FAIL bp_held_isi got=%0d exp=%0d", out_isi, first_isi); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    out_ready = 1'b1; spike_in = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky_overrun got=%b exp=1", overrun); end
    en = 1'b0;
    tick();
  endtask

  // Accept on the same cycle a new window ends: new result loads, no drop.
  task automatic test_back_to_back();
    do_reset();
    stim.delete();
    for (int k = 0; k < 6; k++) stim.push_back(k == 0 || k == 3 || k == 5);
    out_ready = 1'b0;
    start_count(3);
    for (int k = 0; k < 6; k++) begin
      spike_in  = stim[k];
      out_ready = (k == 5);
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    checks++; if (out_count !== CNT_W'(exp_count(3, 5))) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", out_count, exp_count(3, 5)); end
    checks++; if (out_isi !== ISI_W'(exp_isi(5))) begin errors++; $display("FAIL b2b_isi got=%0d exp=%0d", out_isi, exp_isi(5)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    en = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    int bad_valid;
    do_reset();
    start_count(10);
    bad_valid = 0;
    for (int k = 0; k < 5; k++) begin
      spike_in = (k == 1 || k == 3);
      en       = (k != 4);
      tick();
    end
    spike_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid !== 1'b0) bad_valid++;
    end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL abort_valid got=%0d high cycles exp=0", bad_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    // fresh window must start from cleared counters and no previous spike
    start_count(10);
    for (int k = 0; k < 10; k++) begin
      spike_in = (k == 0 || k == 4);
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got=%b exp=1", out_valid); end
    checks++; if (out_count !== CNT_W'(2)) begin errors++; $display("FAIL restart_count got=%0d exp=2", out_count); end
`ifdef SPIKE_RATE_DECODER_ISI_EN
    checks++; if (out_isi !== ISI_W'(4)) begin errors++; $display("FAIL restart_isi got=%0d exp=4", out_isi); end
`else
    checks++; if (out_isi !== ISI_W'(0)) begin errors++; $display("FAIL restart_isi got=%0d exp=0", out_isi); end
`endif
    en = 1'b0; spike_in = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_window();
    do_reset();
    out_ready = 1'b0;
    start_count(10);
    for (int k = 0; k < 23; k++) begin
      spike_in = (k == 2 || k == 5);
      tick();
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL midrst_pre_overrun got=%b exp=1", overrun); end
    rst = 1'b1; spike_in = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", out_count); end
    checks++; if (out_isi !== '0) begin errors++; $display("FAIL midrst_isi got=%0d exp=0", out_isi); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1; win_len = '0;
    test_reset();
    test_directed();
    test_held_high();
    test_saturate();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
